// File: rtl/coherence_bus_ctrl.sv
// ---------------------------------------------------------------------------
// coherence_bus_ctrl
//
// Responder end of the dcache coherence/memory interface for a two-core
// system. Arbitrates the two dcaches' read-miss (dREN), writeback (dWEN) and
// upgrade (cctrans & ccwrite) requests, snoops the non-requesting cache and
// serves two-word blocks either cache-to-cache (with RAM updated in parallel)
// or from RAM. Evictions are written straight to RAM; upgrades issue a
// one-cycle invalidation to the other cache.
//
// Ports (index [i] selects cache i):
//   CLK, RST         clock, synchronous active-high reset
//   dREN/dWEN        per-cache block read / writeback request
//   daddr/dstore     per-cache word address / store (and snoop supply) data
//   cctrans/ccwrite  per-cache coherence transaction / write-intent or dirty
//   dwait/dload      per-cache wait (low one cycle per word) / load data
//   ccwait/ccinv     snoop in progress / invalidate, on the snooped cache
//   ccsnoopaddr      per-cache snoop address
//   ramREN/ramWEN    RAM read / write strobe (never both high)
//   ramaddr/ramstore RAM address / write data
//   ramload/ramwait  RAM read data / busy
//
// Configuration:
//   ARB_RR_EN  defined   -> round-robin grant on simultaneous requests
//              undefined -> fixed priority, cache 0 wins
// ---------------------------------------------------------------------------
module coherence_bus_ctrl #(
    parameter int WORD_W    = 32,
    parameter int BLK_WORDS = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [1:0]             dREN,
    input  logic [1:0]             dWEN,
    input  logic [1:0][WORD_W-1:0] daddr,
    input  logic [1:0][WORD_W-1:0] dstore,
    input  logic [1:0]             cctrans,
    input  logic [1:0]             ccwrite,
    output logic [1:0]             dwait,
    output logic [1:0][WORD_W-1:0] dload,
    output logic [1:0]             ccwait,
    output logic [1:0]             ccinv,
    output logic [1:0][WORD_W-1:0] ccsnoopaddr,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  logic                   ramwait
);

    typedef enum logic [3:0] {
        IDLE, SNOOP, C2C0, C2C1, RAM0, RAM1, WB0, WB1, INV
    } state_t;

    // Blocks are two words, so the word counter is a single bit.
    localparam logic LAST_WORD = 1'(BLK_WORDS - 1);

    state_t     state;
    logic       gnt;        // granted requester r
    logic       oth;        // snooped cache o = ~r
    logic       wcnt;       // words completed in the current block
    logic [1:0] req;
    logic       pick;       // requester selected in IDLE
    logic       orig_req;   // request that started the current transaction
    logic       abort;
    logic       word_done;

    assign req = dREN | dWEN | (cctrans & ccwrite);
    assign oth = ~gnt;

`ifdef ARB_RR_EN
    logic last_grant;

    always_comb begin
        if (req == 2'b11) pick = ~last_grant;
        else              pick = ~req[0];
    end

    // Reset value 1 makes cache 0 the first winner of a tie.
    always_ff @(posedge CLK) begin
        if (RST)                       last_grant <= 1'b1;
        else if (state == IDLE && |req) last_grant <= pick;
    end
`else
    assign pick = ~req[0];
`endif

    function automatic state_t next_word(input state_t s);
        case (s)
            C2C0:    return C2C1;
            RAM0:    return RAM1;
            WB0:     return WB1;
            default: return s;
        endcase
    endfunction

    // The request kind that opened the transaction is implied by the state.
    always_comb begin
        case (state)
            WB0, WB1: orig_req = dWEN[gnt];
            INV:      orig_req = cctrans[gnt];
            default:  orig_req = dREN[gnt];
        endcase
    end

    assign abort     = (state != IDLE) && !orig_req;
    assign word_done = (state inside {C2C0, C2C1, RAM0, RAM1, WB0, WB1}) && !ramwait;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            gnt   <= 1'b0;
            wcnt  <= 1'b0;
        end else if (abort) begin
            // A word strobed in this cycle still completes on the RAM side.
            state <= IDLE;
            wcnt  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wcnt <= 1'b0;
                    if (|req) begin
                        gnt <= pick;
                        if (dWEN[pick])      state <= WB0;
                        else if (dREN[pick]) state <= SNOOP;
                        else                 state <= INV;
                    end
                end
                SNOOP:   state <= (cctrans[oth] & ccwrite[oth]) ? C2C0 : RAM0;
                INV:     state <= IDLE;
                default: begin
                    if (word_done) begin
                        if (wcnt == LAST_WORD) begin
                            state <= IDLE;
                            wcnt  <= 1'b0;
                        end else begin
                            state <= next_word(state);
                            wcnt  <= wcnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // combinational output unassigned (which would infer a latch).
    always_comb begin
        dwait       = 2'b11;
        dload       = '0;
        ccwait      = 2'b00;
        ccinv       = 2'b00;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (state)
            SNOOP: begin
                if (!abort) begin
                    ccwait[oth]      = 1'b1;
                    ccinv[oth]       = ccwrite[gnt];
                    ccsnoopaddr[oth] = daddr[gnt];
                end
            end
            C2C0, C2C1: begin
                if (!abort) begin
                    ccwait[oth]      = 1'b1;
                    ccinv[oth]       = ccwrite[gnt];
                    ccsnoopaddr[oth] = daddr[gnt];
                end
                dload[gnt] = dstore[oth];
                ramWEN     = 1'b1;
                ramaddr    = daddr[gnt];
                ramstore   = dstore[oth];
                dwait[gnt] = ramwait;
            end
            RAM0, RAM1: begin
                ramREN     = 1'b1;
                ramaddr    = daddr[gnt];
                dload[gnt] = ramload;
                dwait[gnt] = ramwait;
            end
            WB0, WB1: begin
                ramWEN     = 1'b1;
                ramaddr    = daddr[gnt];
                ramstore   = dstore[gnt];
                dwait[gnt] = ramwait;
            end
            INV: begin
                if (!abort) begin
                    ccwait[oth]      = 1'b1;
                    ccinv[oth]       = 1'b1;
                    ccsnoopaddr[oth] = daddr[gnt];
                end
                dwait[gnt] = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_coherence_bus_ctrl
//
// Directed bench for coherence_bus_ctrl. Expected per-word results (load
// data, RAM address/data/strobes) are queued when a word is driven and
// compared when the DUT drops dwait for that cache. Control-path outputs
// (snoop, invalidate, idle state) are compared directly at each step.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_coherence_bus_ctrl;

    logic              CLK = 1'b0;
    logic              RST;
    logic [1:0]        dREN, dWEN, cctrans, ccwrite;
    logic [1:0][31:0]  daddr, dstore;
    logic [1:0]        dwait, ccwait, ccinv;
    logic [1:0][31:0]  dload, ccsnoopaddr;
    logic              ramREN, ramWEN, ramwait;
    logic [31:0]       ramaddr, ramstore, ramload;

    int vectors     = 0;
    int miscompares = 0;
    int w0, w1;

    typedef struct {
        logic [31:0] load;
        logic [31:0] addr;
        logic [31:0] store;
        logic        ren;
        logic        wen;
    } exp_t;

    exp_t sb[$];

    coherence_bus_ctrl dut (
        .CLK(CLK), .RST(RST),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .cctrans(cctrans), .ccwrite(ccwrite),
        .dwait(dwait), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramwait(ramwait)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [31:0] load, input logic [31:0] addr,
                        input logic [31:0] store, input logic ren, input logic wen);
        exp_t e;
        e.load = load; e.addr = addr; e.store = store; e.ren = ren; e.wen = wen;
        sb.push_back(e);
    endtask

    // Wait (bounded) for cache c's dwait to drop, then compare the oldest
    // queued expectation against that cycle's outputs.
    task automatic wait_word(input string tag, input int c);
        bit   seen = 1'b0;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            if (dwait[c] == 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_dwait_low"}, 32'(seen), 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_dload"},    dload[c],        e.load);
            check({tag, "_ramaddr"},  ramaddr,         e.addr);
            check({tag, "_ramstore"}, ramstore,        e.store);
            check({tag, "_ramREN"},   32'(ramREN),     32'(e.ren));
            check({tag, "_ramWEN"},   32'(ramWEN),     32'(e.wen));
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge CLK);
        check({tag, "_dwait"},  32'(dwait),  32'h3);
        check({tag, "_ccwait"}, 32'(ccwait), 32'h0);
        check({tag, "_ccinv"},  32'(ccinv),  32'h0);
        check({tag, "_strobe"}, 32'({ramREN, ramWEN}), 32'h0);
    endtask

    initial begin
        RST = 1'b1; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
        daddr = '0; dstore = '0; ramwait = 1'b0; ramload = '0;
        tick(); tick();
        RST = 1'b0;

        // Reset state
        check_idle("rst");
        check("rst_dload",   dload[0] | dload[1], 32'h0);
        check("rst_ramaddr", ramaddr,             32'h0);
        check("rst_snoopad", ccsnoopaddr[0] | ccsnoopaddr[1], 32'h0);
        tick();

        // Cold read miss from cache 0, served by RAM
        dREN = 2'b01; daddr[0] = 32'h100; ramload = 32'hA0A0_0001;
        check_idle("t1_idle");
        tick();
        @(negedge CLK);
        check("t1_snoop_ccwait", 32'(ccwait), 32'h2);
        check("t1_snoop_addr",   ccsnoopaddr[1], 32'h100);
        check("t1_snoop_ccinv",  32'(ccinv), 32'h0);
        check("t1_snoop_dwait",  32'(dwait), 32'h3);
        check("t1_snoop_ren",    32'(ramREN), 32'h0);
        tick();
        push(32'hA0A0_0001, 32'h100, 32'h0, 1'b1, 1'b0);
        wait_word("t1_w0", 0);
        check("t1_w0_ccwait", 32'(ccwait), 32'h0);
        tick();
        daddr[0] = 32'h104; ramload = 32'hA0A0_0002;
        push(32'hA0A0_0002, 32'h104, 32'h0, 1'b1, 1'b0);
        wait_word("t1_w1", 0);
        tick();
        dREN = 2'b00;
        check_idle("t1_done");
        tick();

        // Dirty cache-to-cache: cache 1 misses, cache 0 supplies
        dREN = 2'b10; daddr[1] = 32'h200;
        check_idle("t2_idle");
        tick();
        cctrans = 2'b01; ccwrite = 2'b01; dstore[0] = 32'hDEAD;
        @(negedge CLK);
        check("t2_snoop_ccwait", 32'(ccwait), 32'h1);
        check("t2_snoop_addr",   ccsnoopaddr[0], 32'h200);
        check("t2_snoop_ccinv",  32'(ccinv), 32'h0);
        tick();
        push(32'hDEAD, 32'h200, 32'hDEAD, 1'b0, 1'b1);
        wait_word("t2_w0", 1);
        check("t2_w0_ccwait", 32'(ccwait), 32'h1);
        check("t2_w0_ccinv",  32'(ccinv),  32'h0);
        tick();
        daddr[1] = 32'h204; dstore[0] = 32'hBEEF;
        push(32'hBEEF, 32'h204, 32'hBEEF, 1'b0, 1'b1);
        wait_word("t2_w1", 1);
        check("t2_w1_snoopaddr", ccsnoopaddr[0], 32'h204);
        tick();
        dREN = 2'b00; cctrans = 2'b00; ccwrite = 2'b00;
        check_idle("t2_done");
        tick();

        // Writeback from cache 0 with three cycles of RAM latency
        dWEN = 2'b01; daddr[0] = 32'h300; dstore[0] = 32'h5555_0001; ramwait = 1'b1;
        check_idle("t3_idle");
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("t3_busy_dwait",  32'(dwait),  32'h3);
            check("t3_busy_wen",    32'(ramWEN), 32'h1);
            check("t3_busy_ccwait", 32'(ccwait), 32'h0);
            tick();
        end
        ramwait = 1'b0;
        push(32'h0, 32'h300, 32'h5555_0001, 1'b0, 1'b1);
        wait_word("t3_w0", 0);
        check("t3_w0_ccwait", 32'(ccwait), 32'h0);
        tick();
        daddr[0] = 32'h304; dstore[0] = 32'h5555_0002;
        push(32'h0, 32'h304, 32'h5555_0002, 1'b0, 1'b1);
        wait_word("t3_w1", 0);
        tick();
        dWEN = 2'b00;
        check_idle("t3_done");
        tick();

        // Upgrade from cache 1: one-cycle invalidate of cache 0
        cctrans = 2'b10; ccwrite = 2'b10; daddr[1] = 32'h400;
        check_idle("t4_idle");
        tick();
        push(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        wait_word("t4_inv", 1);
        check("t4_ccwait",    32'(ccwait), 32'h1);
        check("t4_ccinv",     32'(ccinv),  32'h1);
        check("t4_dwait",     32'(dwait),  32'h1);
        check("t4_snoopaddr", ccsnoopaddr[0], 32'h400);
        tick();
        cctrans = 2'b00; ccwrite = 2'b00;
        check_idle("t4_done");
        tick();

        // Simultaneous reads, twice in succession; second one aborted in SNOOP
        w0 = 0;
`ifdef ARB_RR_EN
        w1 = 1;
`else
        w1 = 0;
`endif
        dREN = 2'b11; daddr[0] = 32'h500; daddr[1] = 32'h600; ramload = 32'hB0B0_0001;
        check_idle("t5_idle0");
        tick();
        @(negedge CLK);
        check("t5_grant0", 32'(ccwait), (w0 == 0) ? 32'h2 : 32'h1);
        tick();
        push(32'hB0B0_0001, daddr[w0], 32'h0, 1'b1, 1'b0);
        wait_word("t5_a_w0", w0);
        tick();
        ramload = 32'hB0B0_0002;
        push(32'hB0B0_0002, daddr[w0], 32'h0, 1'b1, 1'b0);
        wait_word("t5_a_w1", w0);
        tick();
        check_idle("t5_idle1");
        tick();
        @(negedge CLK);
        check("t5_grant1", 32'(ccwait), (w1 == 0) ? 32'h2 : 32'h1);
        dREN = 2'b00;
        #1;
        check("t5_abort_ccwait", 32'(ccwait), 32'h0);
        tick();
        check_idle("t5_abort_idle");
        tick();

        // Reset asserted during RAM1
        dREN = 2'b01; daddr[0] = 32'h700; ramload = 32'hC0C0_0001;
        check_idle("t6_idle");
        tick();
        push(32'hC0C0_0001, 32'h700, 32'h0, 1'b1, 1'b0);
        wait_word("t6_w0", 0);
        tick();
        RST = 1'b1; ramwait = 1'b1; daddr[0] = 32'h704;
        @(negedge CLK);
        check("t6_ram1_ren", 32'(ramREN), 32'h1);
        tick();
        check_idle("t6_reset");
        RST = 1'b0; dREN = 2'b00; ramwait = 1'b0;
        tick();
        check_idle("t6_after");

        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- Responder end of the dcache coherence/memory interface for a two-core system.
- Arbitrates between the two dcaches' dREN/dWEN/cctrans requests, snoops the non-requesting cache, and serves two-word blocks either cache-to-cache or from RAM.
- Performs eviction writebacks and MSI upgrade invalidations.
- Sits between the per-core dcaches and the single RAM port.

Parameters:
- WORD_W, 32, data/address word width.
- BLK_WORDS, 2, words per block; fixed at 2; the word counter is 1 bit.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- dREN  in  [1:0]  per-cache block read request (miss)
- dWEN  in  [1:0]  per-cache writeback request (eviction)
- daddr  in  [1:0][WORD_W-1:0]  per-cache word address; the cache steps it per word
- dstore  in  [1:0][WORD_W-1:0]  per-cache store data; also the snoop supply data
- cctrans  in  [1:0]  coherence transaction; from a snooped cache it means "I hold the line"
- ccwrite  in  [1:0]  requester: BusRdX/upgrade intent; snooped cache: line is dirty (M)
- dwait  out  [1:0]  per-cache wait, low for one cycle per completed word
- dload  out  [1:0][WORD_W-1:0]  per-cache load data
- ccwait  out  [1:0]  snoop in progress on that cache
- ccinv  out  [1:0]  invalidate snooped line
- ccsnoopaddr  out  [1:0][WORD_W-1:0]  snoop address
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramwait  in  1  RAM busy; a word completes in any cycle with ramwait=0 and a strobe high

Behaviour:
- Reset (RST sampled high at CLK edge):
  - state=IDLE, word counter=0, grant pointer=0.
  - Outputs: dwait=2'b11, all other outputs 0 (dload/ccsnoopaddr/ramaddr/ramstore=0).
  - Reset mid-transaction aborts immediately; no partial RAM write is retried.
- Requester r, other o = ~r.
- req[i] = dREN[i] | dWEN[i] | (cctrans[i] & ccwrite[i]).
- States and transitions:
  - IDLE:
    - Select r among req (arbitration below); latch r.
    - dWEN[r] -> WB0.
    - else dREN[r] -> SNOOP.
    - else (upgrade) -> INV.
  - SNOOP:
    - ccwait[o]=1, ccsnoopaddr[o]=daddr[r], ccinv[o]=ccwrite[r]; dwait[r]=1.
    - One cycle, then sample o's response: cctrans[o]&ccwrite[o] -> C2C0, else -> RAM0.
  - C2C0/C2C1:
    - ccwait[o]=1, ccsnoopaddr[o]=daddr[r] (live), ccinv[o]=ccwrite[r].
    - dload[r]=dstore[o]; ramWEN=1, ramaddr=daddr[r], ramstore=dstore[o] (memory updated in parallel).
    - dwait[r]=ramwait.
    - Advance C2C0->C2C1->IDLE on ramwait=0.
  - RAM0/RAM1:
    - ramREN=1, ramaddr=daddr[r], dload[r]=ramload, dwait[r]=ramwait.
    - Advance on ramwait=0; RAM1 -> IDLE.
  - WB0/WB1:
    - ramWEN=1, ramaddr=daddr[r], ramstore=dstore[r], dwait[r]=ramwait.
    - Advance on ramwait=0; WB1 -> IDLE.
    - No snoop is issued.
  - INV:
    - ccwait[o]=1, ccsnoopaddr[o]=daddr[r], ccinv[o]=1, dwait[r]=0, for exactly one cycle.
    - -> IDLE.
- Outputs are combinational from state and inputs. dwait for non-granted caches is held at 1.
- ramREN and ramWEN are never both high.
- Abort: if the granted cache drops its originating request (dREN/dWEN/cctrans) mid-transaction:
  - Return to IDLE next cycle; ccwait is cleared in that same cycle.
  - A RAM word already strobed in that cycle completes normally.
- IDLE with no req: all strobes 0, dwait=2'b11.
- A cache is never snooped while it is the granted requester.
- ccwait[r]=0 always.
- Word offset follows daddr[r] bit 2. The controller's word counter is independent and wraps 1->0 on returning to IDLE.

Optional Feature:
- Macro ARB_RR_EN.
- Defined:
  - Round-robin arbitration. When both caches request in IDLE, grant goes to ~last_grant.
  - last_grant updates on each IDLE->non-IDLE transition; reset value 1, so cache 0 wins first.
- Undefined:
  - Fixed priority; cache 0 always wins a simultaneous request.
  - No last_grant register.

Test Plan:
- Cold read miss: dREN[0]=1, daddr[0]=0x100/0x104, cctrans[1]=0, ramwait=0 -> SNOOP with ccwait[1]=1, ccsnoopaddr[1]=0x100; then RAM0/RAM1 each drop dwait[0] for one cycle with dload[0]=ramload; back in IDLE after 3 cycles.
- Dirty cache-to-cache: dREN[1]=1, ccwrite[1]=0; cache 0 answers cctrans[0]=1, ccwrite[0]=1, dstore[0]=0xDEAD/0xBEEF -> dload[1]=0xDEAD then 0xBEEF; ramWEN=1 with the same data at 0x200/0x204; ccinv[0]=0.
- Writeback with RAM latency: dWEN[0]=1, ramwait=1 for 3 cycles then 0 -> dwait[0] stays 1 for 3 cycles, then ramWEN completes word 0; no ccwait asserted.
- Upgrade: cctrans[1]=1, ccwrite[1]=1, dREN/dWEN=0 -> one cycle of ccwait[0]=1, ccinv[0]=1, dwait[1]=0; then IDLE.
- Simultaneous requests with ARB_RR_EN: both dREN high twice in succession -> grants cache 0 then cache 1. Without the macro -> cache 0 both times.
- Reset mid-RAM1: assert RST during RAM1 -> next cycle state IDLE, dwait=2'b11, ramREN=0, ccwait=0.
